// File: rtl/csi2_packet_parser_pkg.sv
// ----------------------------------------------------------------------------
// csi2_packet_parser_pkg
// Shared constants and types for the CSI-2 packet parser:
//   NUM_LANE      - number of byte lanes delivered per clock by the lane aligner
//   DT_FS/DT_FE   - Frame Start / Frame End short-packet data types
//   DT_RAW8       - RAW8 long-packet data type
//   csi2_state_t  - parser FSM states
// No ports (package).
// ----------------------------------------------------------------------------
package csi2_packet_parser_pkg;

    localparam int NUM_LANE = 2;

    localparam logic [5:0] DT_FS   = 6'h00;
    localparam logic [5:0] DT_FE   = 6'h01;
    localparam logic [5:0] DT_RAW8 = 6'h2A;

    typedef enum logic [2:0] {
        DRAIN   = 3'd0,
        IDLE    = 3'd1,
        HDR1    = 3'd2,
        PAYLOAD = 3'd3,
        FOOTER  = 3'd4
    } csi2_state_t;

endpackage

// File: rtl/csi2_packet_parser_crc16.sv
// ----------------------------------------------------------------------------
// csi2_crc16
// Running CSI-2 payload CRC-16 (poly 0x1021 reflected = 0x8408, init 0xFFFF,
// LSB first, no final inversion), two bytes per clock with word[7:0] taken
// first. Only instantiated when CSI2_CRC_CHECK_EN is defined.
// Ports:
//   clk   in  1  - clock
//   word  in  16 - payload word, [7:0] = earlier byte, [15:8] = later byte
//   valid in  1  - fold word into the running CRC this cycle
//   clear in  1  - reload the seed 0xFFFF (has priority over valid)
//   crc   out 16 - registered running CRC
// ----------------------------------------------------------------------------
module csi2_crc16 (
    input  logic        clk,
    input  logic [15:0] word,
    input  logic        valid,
    input  logic        clear,
    output logic [15:0] crc
);

    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc_byte(crc_byte(crc, word[7:0]), word[15:8]);
    end

    always_ff @(posedge clk) begin
        if (clear)      crc <= 16'hFFFF;
        else if (valid) crc <= crc_next;
    end

endmodule

// File: rtl/csi2_packet_parser.sv
// ----------------------------------------------------------------------------
// csi2_packet_parser
// Turns the byte-aligned 2-lane CSI-2 stream into frame/line events and a
// two-pixels-per-clock RAW8 stream for raw2rgb. Short packets become frame
// strobes, RAW8 long-packet payload is forwarded, everything else is dropped.
// Optional feature: define CSI2_CRC_CHECK_EN to check the payload CRC against
// the packet footer (crc_err); otherwise crc_err is tied low.
// Parameters:
//   VC      - virtual channel accepted
//   MAX_WC  - largest legal word count (bytes)
// Ports:
//   clk          in  1  - byte clock
//   rst          in  1  - synchronous active-high reset
//   lane_data    in  16 - [7:0] lane 0 (earlier byte), [15:8] lane 1
//   lane_valid   in  1  - high for one HS burst (one packet)
//   data_out     out 16 - [15:8] earlier pixel, [7:0] later pixel
//   data_valid   out 1  - payload word valid
//   frame_start  out 1  - FS pulse
//   frame_end    out 1  - FE pulse
//   frame_active out 1  - set by FS, cleared by FE
//   line_end     out 1  - pulse after the last word of a RAW8 line
//   line_cnt     out 16 - RAW8 lines completed since last FS (saturating)
//   pkt_err      out 1  - truncated / odd-WC / oversize packet
//   crc_err      out 1  - payload CRC mismatch (with line_end)
// ----------------------------------------------------------------------------
module csi2_packet_parser
    import csi2_packet_parser_pkg::*;
#(
    parameter logic [1:0]  VC     = 2'd0,
    parameter logic [15:0] MAX_WC = 16'd4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*NUM_LANE-1:0]   lane_data,
    input  logic                    lane_valid,
    output logic [15:0]             data_out,
    output logic                    data_valid,
    output logic                    frame_start,
    output logic                    frame_end,
    output logic                    frame_active,
    output logic                    line_end,
    output logic [15:0]             line_cnt,
    output logic                    pkt_err,
    output logic                    crc_err
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    csi2_state_t state;
    logic [7:0]  di_p0;
    logic [7:0]  wc_lsb_p0;
    logic [15:0] remain_p0;
    logic [15:0] wc;
    logic [5:0]  dt;
    logic        crc_bad;

    // Registered outputs
    logic [15:0] data_p1;
    logic        vld_p1;
    logic        fs_p1;
    logic        fe_p1;
    logic        fact_p1;
    logic        le_p1;
    logic [15:0] lcnt_p1;
    logic        perr_p1;
    logic        cerr_p1;

    assign wc = {lane_data[7:0], wc_lsb_p0};
    assign dt = di_p0[5:0];

`ifdef CSI2_CRC_CHECK_EN
    logic [15:0] crc_run;
    logic        crc_clear;
    logic        crc_valid;

    // Seed is reloaded in every non-payload state, so the value seen in
    // FOOTER covers exactly this packet's payload (0xFFFF for WC=0).
    assign crc_clear = (state != PAYLOAD);
    assign crc_valid = (state == PAYLOAD) && lane_valid;

    csi2_crc16 u_crc16 (
        .clk   (clk),
        .word  (lane_data),
        .valid (crc_valid),
        .clear (crc_clear),
        .crc   (crc_run)
    );

    // Footer word is {CRC MSB on lane 1, CRC LSB on lane 0}.
    assign crc_bad = (crc_run != lane_data);
`else
    assign crc_bad = 1'b0;
`endif

    // Stage p0 -> p1: FSM and all output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DRAIN;
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            fs_p1     <= 1'b0;
            fe_p1     <= 1'b0;
            fact_p1   <= 1'b0;
            le_p1     <= 1'b0;
            lcnt_p1   <= '0;
            perr_p1   <= 1'b0;
            cerr_p1   <= 1'b0;
        end else begin
            vld_p1  <= 1'b0;
            fs_p1   <= 1'b0;
            fe_p1   <= 1'b0;
            le_p1   <= 1'b0;
            perr_p1 <= 1'b0;
            cerr_p1 <= 1'b0;

            unique case (state)
                DRAIN: begin
                    if (!lane_valid) state <= IDLE;
                end

                IDLE: begin
                    if (lane_valid) begin
                        di_p0     <= lane_data[7:0];
                        wc_lsb_p0 <= lane_data[15:8];
                        state     <= HDR1;
                    end
                end

                HDR1: begin
                    if (!lane_valid) begin
                        perr_p1 <= 1'b1;
                        state   <= IDLE;
                    end else if (di_p0[7:6] != VC) begin
                        state <= DRAIN;
                    end else if (dt < 6'h10) begin
                        if (dt == DT_FS) begin
                            fs_p1   <= 1'b1;
                            fact_p1 <= 1'b1;
                            lcnt_p1 <= '0;
                        end else if (dt == DT_FE) begin
                            fe_p1   <= 1'b1;
                            fact_p1 <= 1'b0;
                        end
                        state <= DRAIN;
                    end else if (dt != DT_RAW8) begin
                        state <= DRAIN;
                    end else if (wc[0] || (wc > MAX_WC)) begin
                        perr_p1 <= 1'b1;
                        state   <= DRAIN;
                    end else if (wc == 16'd0) begin
                        state <= FOOTER;
                    end else begin
                        remain_p0 <= wc;
                        state     <= PAYLOAD;
                    end
                end

                PAYLOAD: begin
                    if (!lane_valid) begin
                        perr_p1 <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        data_p1   <= {lane_data[7:0], lane_data[15:8]};
                        vld_p1    <= 1'b1;
                        remain_p0 <= remain_p0 - 16'd2;
                        if (remain_p0 == 16'd2) state <= FOOTER;
                    end
                end

                FOOTER: begin
                    if (!lane_valid) begin
                        perr_p1 <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        le_p1   <= 1'b1;
                        cerr_p1 <= crc_bad;
                        lcnt_p1 <= sat_inc16(lcnt_p1);
                        state   <= DRAIN;
                    end
                end

                default: state <= DRAIN;
            endcase
        end
    end

    assign data_out     = data_p1;
    assign data_valid   = vld_p1;
    assign frame_start  = fs_p1;
    assign frame_end    = fe_p1;
    assign frame_active = fact_p1;
    assign line_end     = le_p1;
    assign line_cnt     = lcnt_p1;
    assign pkt_err      = perr_p1;
    assign crc_err      = cerr_p1;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// ----------------------------------------------------------------------------
// tb_csi2_packet_parser
// Directed bench for csi2_packet_parser: frame sequence, truncation, filtered
// packets, illegal WC, CRC footer handling and reset mid-burst. A negedge
// monitor counts output events; scenarios compare event deltas and data words
// with hand-derived values.
// ----------------------------------------------------------------------------
module tb_csi2_packet_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] lane_data;
    logic        lane_valid;
    logic [15:0] data_out;
    logic        data_valid;
    logic        frame_start;
    logic        frame_end;
    logic        frame_active;
    logic        line_end;
    logic [15:0] line_cnt;
    logic        pkt_err;
    logic        crc_err;

    always #5 clk = ~clk;

    csi2_packet_parser #(
        .VC     (2'd0),
        .MAX_WC (16'd4096)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lane_data    (lane_data),
        .lane_valid   (lane_valid),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .frame_active (frame_active),
        .line_end     (line_end),
        .line_cnt     (line_cnt),
        .pkt_err      (pkt_err),
        .crc_err      (crc_err)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- output event monitor ----------------
    int m_dv = 0, m_le = 0, m_pe = 0, m_ce = 0, m_fs = 0, m_fe = 0;
    int m_le_bad = 0, m_ce_bad = 0;
    logic prev_dv = 1'b0;
    logic [15:0] dq[$];

    always @(negedge clk) begin
        if (data_valid) begin
            m_dv++;
            dq.push_back(data_out);
        end
        if (line_end) begin
            m_le++;
            if (!prev_dv) m_le_bad++;
        end
        if (pkt_err) m_pe++;
        if (crc_err) begin
            m_ce++;
            if (!line_end) m_ce_bad++;
        end
        if (frame_start) m_fs++;
        if (frame_end)   m_fe++;
        prev_dv = data_valid;
    end

    int s_dv, s_le, s_pe, s_ce, s_fs, s_fe, s_q;

    task automatic snap();
        s_dv = m_dv; s_le = m_le; s_pe = m_pe; s_ce = m_ce;
        s_fs = m_fs; s_fe = m_fe; s_q = dq.size();
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in ^ {8'h00, b};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

    task automatic drive(input logic v, input logic [15:0] d);
        @(posedge clk);
        #1;
        lane_valid = v;
        lane_data  = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 16'h0000);
    endtask

    task automatic send_short(input logic [7:0] di);
        drive(1'b1, {8'h00, di});
        drive(1'b1, 16'h0000);
        idle(3);
    endtask

    task automatic send_long(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] b0,
                             input int n_words, input logic with_footer, input logic [15:0] fxor);
        logic [15:0] crc;
        logic [7:0]  lo, hi;
        crc = 16'hFFFF;
        drive(1'b1, {wc[7:0], di});
        drive(1'b1, {8'h00, wc[15:8]});
        for (int k = 0; k < n_words; k++) begin
            lo  = b0 + 8'(2 * k);
            hi  = b0 + 8'(2 * k + 1);
            crc = crc_step(crc, lo);
            crc = crc_step(crc, hi);
            drive(1'b1, {hi, lo});
        end
        if (with_footer) drive(1'b1, crc ^ fxor);
        idle(3);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst        = 1'b1;
        lane_valid = 1'b0;
        lane_data  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out",   data_out,     0);
        check("rst_data_valid", data_valid,   0);
        check("rst_line_cnt",   line_cnt,     0);
        check("rst_strobes",    {frame_start, frame_end, frame_active, line_end, pkt_err, crc_err}, 0);
        rst = 1'b0;
        idle(2);

        // Frame sequence: FS, two RAW8 lines of 01..08, FE
        snap();
        send_short(8'h00);
        check("fs_pulse",        m_fs - s_fs, 1);
        check("fs_frame_active", frame_active, 1);
        check("fs_line_cnt",     line_cnt, 0);
        send_long(8'h2A, 16'd8, 8'h01, 4, 1'b1, 16'h0000);
        send_long(8'h2A, 16'd8, 8'h01, 4, 1'b1, 16'h0000);
        check("frame_dv_words", m_dv - s_dv, 8);
        for (int l = 0; l < 2; l++)
            for (int w = 0; w < 4; w++)
                check($sformatf("frame_word_l%0d_w%0d", l, w),
                      (dq.size() > s_q + 4*l + w) ? dq[s_q + 4*l + w] : 16'hDEAD,
                      {8'(2*w + 1), 8'(2*w + 2)});
        check("frame_line_end",  m_le - s_le, 2);
        check("frame_le_timing", m_le_bad, 0);
        check("frame_line_cnt",  line_cnt, 2);
        check("frame_no_errs",   (m_pe - s_pe) + (m_ce - s_ce), 0);
        send_short(8'h01);
        check("fe_pulse",        m_fe - s_fe, 1);
        check("fe_frame_active", frame_active, 0);

        // Truncation after 2 payload words of a WC=8 line
        snap();
        send_long(8'h2A, 16'd8, 8'h01, 2, 1'b0, 16'h0000);
        check("trunc_pkt_err",  m_pe - s_pe, 1);
        check("trunc_no_le",    m_le - s_le, 0);
        check("trunc_dv",       m_dv - s_dv, 2);
        check("trunc_line_cnt", line_cnt, 2);

        // Filtered packets: VC1 RAW8, VC0 RAW10
        snap();
        send_long(8'h6A, 16'd8, 8'h01, 4, 1'b1, 16'h0000);
        send_long(8'h2B, 16'd8, 8'h01, 4, 1'b1, 16'h0000);
        check("filt_no_dv",   m_dv - s_dv, 0);
        check("filt_no_errs", (m_pe - s_pe) + (m_ce - s_ce) + (m_le - s_le), 0);

        // Illegal WC: odd, then MAX_WC+2
        snap();
        send_long(8'h2A, 16'd7, 8'h01, 4, 1'b1, 16'h0000);
        check("odd_wc_pkt_err", m_pe - s_pe, 1);
        check("odd_wc_no_dv",   m_dv - s_dv, 0);
        snap();
        send_long(8'h2A, 16'd4098, 8'h01, 2, 1'b0, 16'h0000);
        check("big_wc_pkt_err", m_pe - s_pe, 1);
        check("big_wc_no_dv",   m_dv - s_dv, 0);

        // CRC: good footer, then footer ^ 0x0001
        snap();
        send_long(8'h2A, 16'd8, 8'h00, 4, 1'b1, 16'h0000);
        check("crc_good_le",  m_le - s_le, 1);
        check("crc_good_err", m_ce - s_ce, 0);
        snap();
        send_long(8'h2A, 16'd8, 8'h00, 4, 1'b1, 16'h0001);
        check("crc_bad_le",  m_le - s_le, 1);
`ifdef CSI2_CRC_CHECK_EN
        check("crc_bad_err", m_ce - s_ce, 1);
`else
        check("crc_bad_err", m_ce - s_ce, 0);
`endif
        check("crc_with_le",   m_ce_bad, 0);
        check("crc_line_cnt",  line_cnt, 4);

        // FS clears line_cnt; FE with frame inactive still pulses
        snap();
        send_short(8'h00);
        check("fs2_line_cnt", line_cnt, 0);
        send_short(8'h01);
        send_short(8'h01);
        check("fe_inactive_pulses", m_fe - s_fe, 2);
        check("fe_inactive_level",  frame_active, 0);

        // Reset mid-payload with lane_valid held high
        send_short(8'h00);
        drive(1'b1, 16'h082A);
        drive(1'b1, 16'h0000);
        drive(1'b1, 16'h0201);
        drive(1'b1, 16'h0403);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        lane_data = 16'h0605;
        @(posedge clk);
        #1;
        check("midrst_data_out",   data_out, 0);
        check("midrst_outs",       {data_valid, frame_active, frame_start, frame_end, line_end, pkt_err, crc_err}, 0);
        check("midrst_line_cnt",   line_cnt, 0);
        rst = 1'b0;
        snap();
        drive(1'b1, 16'h0807);
        drive(1'b1, 16'hA5A5);
        idle(3);
        check("midrst_ignored", (m_dv - s_dv) + (m_le - s_le) + (m_pe - s_pe), 0);
        send_short(8'h00);
        check("midrst_fs",        m_fs - s_fs, 1);
        check("midrst_fs_active", frame_active, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
